// File: rtl/wdt_pkg.sv
// wdt_pkg: shared state encoding, config addresses and default kick gap for the watchdog supervisor
package wdt_pkg;
  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_KICK    = 2'd2,
    ST_RECOVER = 2'd3
  } wdt_state_e;
  localparam logic CFG_ADDR_WAIT = 1'b0;
  localparam logic CFG_ADDR_RST  = 1'b1;
  localparam int   KICK_GAP_DEF  = 8;
endpackage

// File: rtl/wdt_cfg_regs.sv
// wdt_cfg_regs: wait/reset period registers with nonzero write validation, sticky lock and error pulse
module wdt_cfg_regs
  import wdt_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEF_WAIT = 1000,
  parameter int DEF_RST  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_we,
  input  logic             i_cfg_addr,
  input  logic [WIDTH-1:0] i_cfg_wdata,
  input  logic             i_cfg_lock,
  output logic [WIDTH-1:0] o_wait_period,
  output logic [WIDTH-1:0] o_rst_period,
  output logic             o_cfg_err
);
  logic lock;
  logic ok;
  assign ok = i_cfg_we & ~lock & |i_cfg_wdata;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wait_period <= WIDTH'(DEF_WAIT);
      o_rst_period  <= WIDTH'(DEF_RST);
      o_cfg_err     <= 1'b0;
      lock          <= 1'b0;
    end else begin
      if (ok && i_cfg_addr == CFG_ADDR_WAIT) o_wait_period <= i_cfg_wdata;
      if (ok && i_cfg_addr == CFG_ADDR_RST) o_rst_period <= i_cfg_wdata;
      o_cfg_err <= i_cfg_we & ~ok;
      lock      <= lock | i_cfg_lock;
    end
  end
endmodule

// File: rtl/wdt_supervisor.sv
// wdt_supervisor: merges task alive pulses into rate-limited watchdog clears and owns period config
module wdt_supervisor
  import wdt_pkg::*;
#(
  parameter int N_TASKS  = 4,
  parameter int WIDTH    = 32,
  parameter int DEF_WAIT = 1000,
  parameter int DEF_RST  = 16,
  parameter int KICK_GAP = KICK_GAP_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_TASKS-1:0] i_task_alive,
  input  logic [N_TASKS-1:0] i_task_en,
  input  logic               i_cfg_we,
  input  logic               i_cfg_addr,
  input  logic [WIDTH-1:0]   i_cfg_wdata,
  input  logic               i_cfg_lock,
  input  logic               i_wdt_hw_rst,
  output logic               o_clrwdt,
  output logic [WIDTH-1:0]   o_wait_period,
  output logic [WIDTH-1:0]   o_rst_period,
  output logic               o_cfg_err,
  output logic [N_TASKS-1:0] o_missing,
  output logic [1:0]         o_state
);
  localparam int GW = $clog2(KICK_GAP + 1);
  wdt_state_e state, state_n;
  logic [N_TASKS-1:0] pending, pending_n, live, missing_n;
  logic [GW-1:0] gap, gap_n;
  logic hw_q, rise, full;
  always_comb begin
    live      = i_task_alive & i_task_en;
    rise      = i_wdt_hw_rst & ~hw_q;
    full      = |i_task_en && ((pending | live) & i_task_en) == i_task_en && gap == '0;
    gap_n     = state == ST_KICK ? GW'(KICK_GAP - 1) : gap == '0 ? '0 : gap - 1'b1;
    missing_n = rise ? i_task_en & ~pending : o_missing;
    pending_n = rise ? '0 : state == ST_KICK ? live : state == ST_COLLECT ? pending | live : '0;
    state_n   = rise                 ? ST_RECOVER :
                state == ST_INIT     ? ST_KICK :
                state == ST_KICK     ? ST_COLLECT :
                state == ST_RECOVER  ? (i_wdt_hw_rst ? ST_RECOVER : ST_INIT) :
                full                 ? ST_KICK : ST_COLLECT;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_INIT;
      pending   <= '0;
      gap       <= '0;
      hw_q      <= 1'b0;
      o_missing <= '0;
      o_clrwdt  <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      gap       <= gap_n;
      hw_q      <= i_wdt_hw_rst;
      o_missing <= missing_n;
      o_clrwdt  <= state_n == ST_KICK;
    end
  end
  assign o_state = state;
  wdt_cfg_regs #(.WIDTH(WIDTH), .DEF_WAIT(DEF_WAIT), .DEF_RST(DEF_RST)) u_cfg (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_wdata   (i_cfg_wdata),
    .i_cfg_lock    (i_cfg_lock),
    .o_wait_period (o_wait_period),
    .o_rst_period  (o_rst_period),
    .o_cfg_err     (o_cfg_err)
  );
endmodule

// File: tb/tb_wdt_supervisor.sv
// tb_wdt_supervisor: randomized check of wdt_supervisor against a behavioural model
module tb_wdt_supervisor;
  localparam int N = 4, W = 32, DW = 1000, DR = 16, GAP = 8;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic [N-1:0] i_task_alive = '0, i_task_en = '0;
  logic i_cfg_we = 1'b0, i_cfg_addr = 1'b0, i_cfg_lock = 1'b0, i_wdt_hw_rst = 1'b0;
  logic [W-1:0] i_cfg_wdata = '0;
  logic o_clrwdt, o_cfg_err;
  logic [W-1:0] o_wait_period, o_rst_period;
  logic [N-1:0] o_missing;
  logic [1:0] o_state;
  wdt_supervisor #(.N_TASKS(N), .WIDTH(W), .DEF_WAIT(DW), .DEF_RST(DR), .KICK_GAP(GAP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_task_alive(i_task_alive), .i_task_en(i_task_en),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
    .i_cfg_lock(i_cfg_lock), .i_wdt_hw_rst(i_wdt_hw_rst), .o_clrwdt(o_clrwdt),
    .o_wait_period(o_wait_period), .o_rst_period(o_rst_period), .o_cfg_err(o_cfg_err),
    .o_missing(o_missing), .o_state(o_state)
  );
  always #5 i_clk = ~i_clk;
  int tests = 0, fails = 0;
  bit seen[N];
  int since, miss_e;
  bit booting, kicking, recovering, prev_hw, locked, err_e;
  logic [W-1:0] wait_e, rst_e;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) seen[i] = 1'b0;
    since = GAP; miss_e = 0;
    booting = 1'b1; kicking = 1'b0; recovering = 1'b0; prev_hw = 1'b0;
    locked = 1'b0; err_e = 1'b0; wait_e = DW; rst_e = DR;
  endtask
  task automatic check_outputs();
    check("clrwdt", 32'(o_clrwdt), 32'(kicking));
    check("state", 32'(o_state), recovering ? 32'd3 : kicking ? 32'd2 : booting ? 32'd0 : 32'd1);
    check("missing", 32'(o_missing), 32'(miss_e));
    check("wait_period", o_wait_period, wait_e);
    check("rst_period", o_rst_period, rst_e);
    check("cfg_err", 32'(o_cfg_err), 32'(err_e));
  endtask
  task automatic step(input logic [N-1:0] alive, input logic [N-1:0] en, input logic we,
                      input logic addr, input logic [W-1:0] wdata, input logic lock, input logic hw);
    bit all;
    int nxt;
    @(negedge i_clk);
    i_task_alive = alive; i_task_en = en; i_cfg_we = we; i_cfg_addr = addr;
    i_cfg_wdata = wdata; i_cfg_lock = lock; i_wdt_hw_rst = hw;
    @(posedge i_clk);
    nxt = kicking ? 1 : (since < GAP ? since + 1 : since);
    if (hw && !prev_hw) begin
      miss_e = 0;
      for (int i = 0; i < N; i++) begin
        if (en[i] && !seen[i]) miss_e |= (1 << i);
        seen[i] = 1'b0;
      end
      recovering = 1'b1; kicking = 1'b0; booting = 1'b0;
    end else if (recovering) begin
      if (!hw) begin recovering = 1'b0; booting = 1'b1; end
    end else if (booting) begin
      booting = 1'b0; kicking = 1'b1;
    end else if (kicking) begin
      kicking = 1'b0;
      for (int i = 0; i < N; i++) seen[i] = alive[i] && en[i];
    end else begin
      all = en != '0;
      for (int i = 0; i < N; i++) begin
        if (alive[i] && en[i]) seen[i] = 1'b1;
        if (en[i] && !seen[i]) all = 1'b0;
      end
      if (all && since >= GAP) kicking = 1'b1;
    end
    since = nxt;
    prev_hw = hw;
    err_e = we && (locked || wdata == '0);
    if (we && !locked && wdata != '0) begin
      if (addr) rst_e = wdata; else wait_e = wdata;
    end
    if (lock) locked = 1'b1;
    #1 check_outputs();
  endtask
  task automatic random_run(input int cycles);
    logic [N-1:0] en = 4'hF;
    int hw_cnt = 0;
    logic hw, we;
    logic [W-1:0] wd;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 99) == 0) en = N'($urandom);
      else if ($urandom_range(0, 59) == 0) en = 4'hF;
      hw = 1'b0;
      if (hw_cnt > 0) begin hw = 1'b1; hw_cnt--; end
      else if ($urandom_range(0, 149) == 0) hw_cnt = $urandom_range(1, 5);
      we = $urandom_range(0, 19) == 0;
      wd = $urandom_range(0, 7) == 0 ? '0 : W'($urandom_range(1, 5000));
      step(N'($urandom) & N'($urandom), en, we, 1'($urandom), wd,
           $urandom_range(0, 399) == 0, hw);
    end
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge i_clk);
    #1 check_outputs();
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    step(4'h0, 4'hF, 0, 0, 0, 0, 0);
    step(4'h0, 4'hF, 1, 0, 0, 0, 0);
    step(4'h0, 4'hF, 1, 0, 500, 0, 0);
    step(4'h0, 4'hF, 0, 0, 0, 1, 0);
    step(4'h0, 4'hF, 1, 0, 200, 0, 0);
    step(4'h0, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(4'h0, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(N'(1 << i), 4'hF, 0, 0, 0, 0, 0);
    step(4'h0, 4'hF, 0, 0, 0, 0, 0);
    step(4'hF, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(4'h0, 4'hF, 0, 0, 0, 0, 0);
    step(4'b1011, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(4'hF, 4'hF, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(4'h0, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(N'($urandom), 4'h0, 0, 0, 0, 0, 0);
    random_run(1500);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    random_run(1500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
